// File: rtl/ft600_pkg.sv
// Shared constants and payload types for the FT600 245-mode synchronous FIFO device model.
package ft600_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    localparam logic [BE_W-1:0] BE_FULL = 2'b11;

    // Active-low bus levels
    localparam logic OE_ON     = 1'b0;
    localparam logic OE_OFF    = 1'b1;
    localparam logic RD_ON     = 1'b0;
    localparam logic WR_ON     = 1'b0;
    localparam logic TXE_READY = 1'b0;
    localparam logic TXE_BUSY  = 1'b1;
    localparam logic RXF_AVAIL = 1'b0;
    localparam logic RXF_EMPTY = 1'b1;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } snk_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is visible combinationally.
module sync_fifo #(
    parameter int unsigned W  = 16,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= push_data;
    end

    assign head  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count = wp - rp;

endmodule

// File: rtl/ft600_245_device.sv
// FT600 chip-side responder for the 245 synchronous FIFO bus: generates ft_clk,
// serves the source FIFO on master reads and captures master writes into the sink FIFO.
module ft600_245_device
    import ft600_pkg::*;
#(
    parameter int unsigned SRC_AW = 4,
    parameter int unsigned SNK_AW = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              snk_valid,
    output logic [DATA_W-1:0] snk_data,
    output logic [BE_W-1:0]   snk_be,
    input  logic              snk_ready,
    output logic              ft_clk,
    inout  logic [DATA_W-1:0] ft_data,
    inout  logic [BE_W-1:0]   ft_be,
    output logic              ft_txe,
    output logic              ft_rxf,
    input  logic              ft_oe,
    input  logic              ft_rd,
    input  logic              ft_wr,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned SNK_DEPTH = 1 << SNK_AW;
    localparam int unsigned SNK_CW    = SNK_AW + 1;
    localparam int unsigned SRC_CW    = SRC_AW + 1;
    localparam int unsigned SNK_W     = $bits(snk_word_t);

    logic              rise;
    logic              fall;
    logic              bus_en;
    logic [DATA_W-1:0] drv_data;
    logic [BE_W-1:0]   drv_be;

    logic              src_push;
    logic              src_pop;
    logic [DATA_W-1:0] src_head;
    logic              src_full;
    logic              src_empty;
    logic [SRC_AW:0]   src_count;

    logic              snk_push;
    logic              snk_pop;
    snk_word_t         snk_in;
    snk_word_t         snk_head;
    logic              snk_full;
    logic              snk_empty;
    logic [SNK_AW:0]   snk_count;

    logic              wr_req;
    logic              ovf_inc;
    logic              err_inc;

    // ft_clk is low before a rise edge and high before a fall edge
    assign rise = !ft_clk;
    assign fall = ft_clk;

    // Bus is released immediately on reset even if the master still asserts oe
    assign bus_en  = (ft_oe == OE_ON) && !rst;
    assign ft_data = bus_en ? drv_data : 'z;
    assign ft_be   = bus_en ? drv_be   : 'z;

    assign src_ready = !src_full;
    assign src_push  = src_valid && src_ready;
    assign src_pop   = rise && (ft_oe == OE_ON) && (ft_rd == RD_ON) && (ft_rxf == RXF_AVAIL);

    assign wr_req   = rise && (ft_wr == WR_ON) && (ft_oe == OE_OFF);
    assign snk_push = wr_req && !snk_full;
    assign ovf_inc  = wr_req && snk_full;
    assign snk_in   = '{be: ft_be, data: ft_data};

    assign snk_valid = !snk_empty;
    assign snk_pop   = snk_valid && snk_ready;
    assign snk_data  = snk_valid ? snk_head.data : '0;
    assign snk_be    = snk_valid ? snk_head.be   : '0;

    // Contention, read+write together, or a read strobe with nothing offered
    assign err_inc = rise && (((ft_wr == WR_ON) && (ft_oe == OE_ON)) ||
                              ((ft_rd == RD_ON) && (ft_wr == WR_ON)) ||
                              ((ft_rd == RD_ON) && (ft_rxf == RXF_EMPTY)));

    sync_fifo #(
        .W  (DATA_W),
        .AW (SRC_AW)
    ) u_src_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (src_push),
        .push_data (src_data),
        .pop       (src_pop),
        .head      (src_head),
        .full      (src_full),
        .empty     (src_empty),
        .count     (src_count)
    );

    sync_fifo #(
        .W  (SNK_W),
        .AW (SNK_AW)
    ) u_snk_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (snk_push),
        .push_data (snk_in),
        .pop       (snk_pop),
        .head      (snk_head),
        .full      (snk_full),
        .empty     (snk_empty),
        .count     (snk_count)
    );

    // Status and drive update on the fall edge; counters step on the rise edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ft_clk   <= 1'b0;
            ft_rxf   <= RXF_EMPTY;
            ft_txe   <= TXE_BUSY;
            drv_data <= '0;
            drv_be   <= '0;
            ovf_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            ft_clk <= !ft_clk;
            if (fall) begin
                ft_rxf   <= (src_count == SRC_CW'(0)) ? RXF_EMPTY : RXF_AVAIL;
                ft_txe   <= (snk_count >= SNK_CW'(SNK_DEPTH - 1)) ? TXE_BUSY : TXE_READY;
                drv_data <= src_head;
                drv_be   <= src_empty ? '0 : BE_FULL;
            end
            if (ovf_inc && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
